// File: rtl/mskrnd_lfsr_source_if.sv
// Seed and random-word streams of the masked-gadget randomness source.
// master: the randomness source itself; slave: the seeding agent / gadget consumer.
interface mskrnd_lfsr_source_if #(
    parameter int RND_W = 1
);
    logic [127:0]     seed;
    logic             seed_valid;
    logic             seed_ready;
    logic [RND_W-1:0] rnd_out;
    logic             rnd_valid;
    logic             rnd_ready;

    modport master (
        input  seed, seed_valid, rnd_ready,
        output seed_ready, rnd_out, rnd_valid
    );

    modport slave (
        output seed, seed_valid, rnd_ready,
        input  seed_ready, rnd_out, rnd_valid
    );
endinterface

// File: rtl/mskrnd_lfsr_source.sv
// 128-bit LFSR fresh-randomness source for HPC2 AND gadgets.
// Polynomial x^128+x^126+x^101+x^99+1, RND_W shifts unrolled per step;
// rnd_out bit k is the feedback bit of shift k within the step.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | unseeded, seed_ready=1, no output
// WARMUP | one discarded/priming step per cycle, cnt counts 0..WARMUP-1
// RUN    | rnd_out valid, steps only when the consumer takes a word
module mskrnd_lfsr_source #(
    parameter int d         = 2,
    parameter int N_GADGETS = 1,
    parameter int RND_W     = N_GADGETS * d * (d - 1) / 2,
    parameter int WARMUP    = 4
) (
    input  logic                clk,
    input  logic                syn_rst,
    mskrnd_lfsr_source_if.master bus
);
    localparam int CNT_W = (WARMUP < 1) ? 1 : $clog2(WARMUP + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WARMUP - 1);

    if (RND_W < 1 || RND_W > 128) begin : g_bad_rnd_w
        $error("RND_W must be within 1..128");
    end
    if (WARMUP < 1) begin : g_bad_warmup
        $error("WARMUP must be at least 1");
    end

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WARMUP = 2'd1,
        S_RUN    = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [127:0]     lfsr;
    logic [127:0]     lfsr_step;
    logic [127:0]     seed_load;
    logic [RND_W-1:0] word_step;
    logic [RND_W-1:0] rnd_out_r;
    logic             rnd_valid_r;
    logic             seed_ready_r;

    // The all-zero state would lock the LFSR, so a zero seed maps to 1.
    assign seed_load = (bus.seed == 128'h0) ? 128'h1 : bus.seed;

    // One step: RND_W single shifts unrolled, collecting each feedback bit.
    always_comb begin
        logic [127:0] s;
        logic         fb;
        s         = lfsr;
        fb        = 1'b0;
        word_step = '0;
        for (int k = 0; k < RND_W; k++) begin
            fb           = s[127] ^ s[125] ^ s[100] ^ s[98];
            word_step[k] = fb;
            s            = {s[126:0], fb};
        end
        lfsr_step = s;
    end

    // Sequencing FSM with registered handshake outputs; a seed load in RUN
    // overrides any step in the same cycle.
    always_ff @(posedge clk) begin
        if (syn_rst) begin
            state        <= S_IDLE;
            cnt          <= '0;
            lfsr         <= 128'h1;
            rnd_out_r    <= '0;
            rnd_valid_r  <= 1'b0;
            seed_ready_r <= 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.seed_valid && seed_ready_r) begin
                        lfsr         <= seed_load;
                        cnt          <= '0;
                        seed_ready_r <= 1'b0;
                        state        <= S_WARMUP;
                    end
                end
                S_WARMUP: begin
                    lfsr      <= lfsr_step;
                    rnd_out_r <= word_step;
                    if (cnt == CNT_LAST) begin
                        seed_ready_r <= 1'b1;
                        rnd_valid_r  <= 1'b1;
                        state        <= S_RUN;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_RUN: begin
                    if (bus.seed_valid && seed_ready_r) begin
                        lfsr         <= seed_load;
                        cnt          <= '0;
                        seed_ready_r <= 1'b0;
                        rnd_valid_r  <= 1'b0;
                        state        <= S_WARMUP;
                    end else if (bus.rnd_ready) begin
                        lfsr      <= lfsr_step;
                        rnd_out_r <= word_step;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.rnd_out    = rnd_out_r;
    assign bus.rnd_valid  = rnd_valid_r;
    assign bus.seed_ready = seed_ready_r;
endmodule
